pipelined_barrel_rotator: RTL
=============================

PIPELINED_BARREL_ROTATOR -- requirements
Module: pipelined_barrel_rotator

Interface
REQ-001 Parameter N, default 8: data width; SHALL be a power of two, at least 4.
REQ-002 Parameter SW, default $clog2(N): shift-amount width; SHALL NOT be overridden independently of N.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 up_valid  input  1  input transaction present.
REQ-006 up_ready  output  1  block accepts the input transaction this cycle.
REQ-007 up_data  input  N  operand.
REQ-008 up_shift  input  SW  shift amount, 0..N-1.
REQ-009 up_dir  input  1  direction: 0 = left, 1 = right.
REQ-010 up_mode  input  2  operation: 00 = rotate, 01 = logical, 10 = arithmetic, 11 = reserved.
REQ-011 down_valid  output  1  result present.
REQ-012 down_ready  input  1  consumer accepts the result this cycle.
REQ-013 down_data  output  N  result.

Function
REQ-014 Rotate SHALL be circular: for N=8, right by 3 maps ABCDEFGH to FGHABCDE; left by 3 maps it to DEFGHABC.
REQ-015 Logical mode SHALL zero-fill vacated bits in either direction.
REQ-016 Arithmetic right SHALL fill vacated bits with up_data[N-1]; arithmetic left SHALL equal logical left.
REQ-017 Mode 11 SHALL behave as rotate.
REQ-018 up_shift = 0 SHALL pass up_data unchanged in every mode and direction.
REQ-019 The datapath SHALL have SW registered stages; stage k SHALL conditionally shift by 2^k, using bit k of up_shift.
REQ-020 Latency SHALL be exactly SW cycles from the input handshake to down_valid, with no stall in between.
REQ-021 Each stage SHALL carry valid, data, remaining shift bits, dir and mode alongside the data.
REQ-022 A transfer SHALL occur only on a cycle where valid and ready are both high, on either port.
REQ-023 up_ready SHALL be !down_valid || down_ready, and SHALL be a global pipeline-advance enable.
REQ-024 When advance is low, every stage register SHALL hold its value.
  - down_data and down_valid SHALL stay stable until the output handshake completes.
REQ-025 When advance is high and up_valid is low, a bubble (valid = 0) SHALL enter stage 0.
REQ-026 Bubbles SHALL NOT be collapsed.
REQ-027 Back-to-back inputs SHALL give back-to-back outputs, one per cycle, while down_ready stays high.
REQ-028 down_data SHALL be a don't-care while down_valid is low.
  - The implementation SHALL still avoid X on down_data after reset; data registers reset to 0.

Reset
REQ-029 While rst is high, all stage valid bits SHALL clear on the next edge; down_valid SHALL read 0 and down_data SHALL read 0.
REQ-030 A reset asserted mid-operation SHALL discard every in-flight transaction; none SHALL emerge after reset deasserts.
REQ-031 up_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 A shared package barrel_pkg SHALL hold:
  - the mode enum (MODE_ROT, MODE_LOG, MODE_ARI, MODE_RSV);
  - the direction constants DIR_LEFT and DIR_RIGHT.
REQ-033 One sub-module, barrel_rotator_stage, SHALL be provided:
  - parameters N and K;
  - combinational conditional shift by 2^K, with fill selected by mode, dir and msb;
  - it SHALL be instantiated SW times in a generate loop, with registers in the parent.
REQ-034 Sign fill for arithmetic right SHALL use the original operand msb, carried through the pipeline.
  - The current intermediate msb SHALL NOT be used.

Verification (N=8, SW=3)
REQ-035 Rotate right by 3: 8'b1010_0011, dir=1, mode=00 -> 8'b0111_0100, with down_valid exactly 3 cycles later.
REQ-036 Rotate left by 3, plus logical left by 1:
  - 8'b1010_0011, dir=0, mode=00, shift=3 -> 8'b0001_1101;
  - 8'b1000_0001, dir=0, mode=01, shift=1 -> 8'b0000_0010.
REQ-037 Arithmetic and logical right:
  - 8'b1000_0000, dir=1, mode=10, shift=2 -> 8'b1110_0000;
  - the same with mode=01 -> 8'b0010_0000;
  - shift=0, any mode -> input unchanged.
REQ-038 Backpressure:
  - stimulus: 5 back-to-back inputs; down_ready low for 4 cycles after the first output;
  - required: outputs in order, none lost or duplicated, down_data stable while stalled, up_ready low during the stall.
REQ-039 Reset mid-flight: 3 inputs accepted, then rst pulsed for 1 cycle -> down_valid stays 0 until new inputs arrive.
REQ-040 Randomised scoreboard: 1000 random data/shift/dir/mode with random down_ready -> every result matches the reference model.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel rotator.
//   mode_e    : operation selected by up_mode
//               (rotate, logical shift, arithmetic shift, reserved = rotate)
//   DIR_LEFT  : up_dir value for a left shift/rotate
//   DIR_RIGHT : up_dir value for a right shift/rotate
package barrel_pkg;

  typedef enum logic [1:0] {
    MODE_ROT = 2'b00,
    MODE_LOG = 2'b01,
    MODE_ARI = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_rotator_stage.sv
// One combinational stage of the barrel rotator: shifts or rotates the
// operand by 2^K when i_en is set, otherwise passes it through unchanged.
//   i_data : operand entering this stage
//   i_en   : shift-amount bit K (1 = apply the 2^K step)
//   i_dir  : DIR_LEFT / DIR_RIGHT
//   i_mode : rotate / logical / arithmetic / reserved (reserved = rotate)
//   i_msb  : msb of the original operand, used as the arithmetic fill bit
//   o_data : stage result
module barrel_rotator_stage
  import barrel_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic [N-1:0] i_data,
  input  logic         i_en,
  input  logic         i_dir,
  input  mode_e        i_mode,
  input  logic         i_msb,
  output logic [N-1:0] o_data
);

  localparam int S = 1 << K;

  logic [N-1:0] w_rot_l;
  logic [N-1:0] w_rot_r;
  logic [N-1:0] w_log_l;
  logic [N-1:0] w_log_r;
  logic [N-1:0] w_ari_r;

  assign w_rot_l = {i_data[N-S-1:0], i_data[N-1:N-S]};
  assign w_rot_r = {i_data[S-1:0], i_data[N-1:S]};
  assign w_log_l = {i_data[N-S-1:0], {S{1'b0}}};
  assign w_log_r = {{S{1'b0}}, i_data[N-1:S]};
  // The fill bit is the original operand msb; after an earlier arithmetic
  // step the intermediate msb already equals it, but a carried copy keeps
  // every stage independent of what the previous stages did.
  assign w_ari_r = {{S{i_msb}}, i_data[N-1:S]};

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_mode)
        MODE_LOG: o_data = (i_dir == DIR_RIGHT) ? w_log_r : w_log_l;
        // Arithmetic left is identical to logical left.
        MODE_ARI: o_data = (i_dir == DIR_RIGHT) ? w_ari_r : w_log_l;
        default:  o_data = (i_dir == DIR_RIGHT) ? w_rot_r : w_rot_l;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_rotator.sv
// Pipelined barrel rotator/shifter with valid/ready handshakes.
// SW registered stages; stage k applies the 2^k step selected by bit k of
// the shift amount. Latency is SW cycles. A single advance enable
// (up_ready) moves the whole pipeline, so bubbles are kept and every stage
// holds while the output is stalled.
// SW must equal $clog2(N) and N must be a power of two, at least 4.
//   clk, rst   : clock, synchronous active-high reset
//   up_valid   : input transaction present
//   up_ready   : input accepted this cycle (pipeline advances)
//   up_data    : operand
//   up_shift   : shift amount 0..N-1
//   up_dir     : 0 = left, 1 = right
//   up_mode    : 00 rotate, 01 logical, 10 arithmetic, 11 rotate
//   down_valid : result present
//   down_ready : consumer accepts the result
//   down_data  : result (0 after reset)
module pipelined_barrel_rotator
  import barrel_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  input  logic          up_dir,
  input  logic [1:0]    up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  logic w_adv;

  // Per-stage valid and data; the last entry drives the output port.
  logic          r_vld_p  [SW];
  logic [N-1:0]  r_data_p [SW];
  // Sideband is only needed by the stages that follow, so the final stage
  // does not register it.
  logic [SW-1:0] r_rem_p  [SW-1];
  logic          r_dir_p  [SW-1];
  mode_e         r_mode_p [SW-1];
  logic          r_msb_p  [SW-1];

  assign w_adv      = !r_vld_p[SW-1] || down_ready;
  assign up_ready   = w_adv;
  assign down_valid = r_vld_p[SW-1];
  assign down_data  = r_data_p[SW-1];

  for (genvar k = 0; k < SW; k++) begin : g_stage
    logic          w_vld;
    logic [N-1:0]  w_din;
    logic [N-1:0]  w_dout;
    logic [SW-1:0] w_rem;
    logic          w_dir;
    mode_e         w_mode;
    logic          w_msb;

    if (k == 0) begin : g_src_port
      assign w_vld  = up_valid;
      assign w_din  = up_data;
      assign w_rem  = up_shift;
      assign w_dir  = up_dir;
      assign w_mode = mode_e'(up_mode);
      assign w_msb  = up_data[N-1];
    end else begin : g_src_reg
      assign w_vld  = r_vld_p[k-1];
      assign w_din  = r_data_p[k-1];
      assign w_rem  = r_rem_p[k-1];
      assign w_dir  = r_dir_p[k-1];
      assign w_mode = r_mode_p[k-1];
      assign w_msb  = r_msb_p[k-1];
    end

    // The remaining shift bits are consumed lsb-first, so bit 0 always
    // belongs to the current stage.
    barrel_rotator_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .i_data (w_din),
      .i_en   (w_rem[0]),
      .i_dir  (w_dir),
      .i_mode (w_mode),
      .i_msb  (w_msb),
      .o_data (w_dout)
    );

    // Stage k register boundary
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld_p[k]  <= 1'b0;
        r_data_p[k] <= '0;
      end else if (w_adv) begin
        r_vld_p[k]  <= w_vld;
        r_data_p[k] <= w_dout;
      end
    end

    if (k < SW - 1) begin : g_side
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rem_p[k]  <= '0;
          r_dir_p[k]  <= DIR_LEFT;
          r_mode_p[k] <= MODE_ROT;
          r_msb_p[k]  <= 1'b0;
        end else if (w_adv) begin
          r_rem_p[k]  <= {1'b0, w_rem[SW-1:1]};
          r_dir_p[k]  <= w_dir;
          r_mode_p[k] <= w_mode;
          r_msb_p[k]  <= w_msb;
        end
      end
    end else begin : g_last
      // All higher remaining bits have been consumed by this point.
      logic w_unused_rem;
      assign w_unused_rem = ^w_rem[SW-1:1];
    end
  end

endmodule
